tdma_burst_scheduler: RTL and testbench

//   Owns TDMA slot/frame timing. Holds a per-slot reservation table filled by NUM_REQ requesters.

---
 rtl/tdma_burst_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_tdma_burst_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdma_burst_scheduler.sv
// TDMA slot/frame timer with a per-slot reservation table, round-robin request
// acceptance and a fire/drop/re-arm handshake with the burst transmitter.
module tdma_burst_scheduler #(
   parameter int unsigned CLOCKS_PER_SLOT = 1250,
   parameter int unsigned SLOTS_PER_FRAME = 8,
   parameter int unsigned NUM_REQ         = 2,
   parameter int unsigned SLOT_W          = 3
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      is_armed,
   output logic                      fire_burst,
   output logic                      grant_valid,
   output logic                      miss_valid,
   output logic [1:0]                owner_id,
   output logic                      slot_strobe,
   output logic [SLOT_W-1:0]         slot_index,
   output logic [15:0]               frame_count,
   output logic                      busy
);

   localparam int unsigned        TIMER_W    = $clog2(CLOCKS_PER_SLOT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLOCKS_PER_SLOT - 1);
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOTS_PER_FRAME - 1);
   localparam logic [5:0]         DROP_LAST  = 6'd63;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      WAIT_DROP,
      BUSY
   } state_t;

   state_t state, state_next;

   logic [TIMER_W-1:0]         timer;
   logic [SLOTS_PER_FRAME-1:0] tbl_valid;
   logic [1:0]                 tbl_owner [SLOTS_PER_FRAME];
   logic [1:0]                 rr_ptr;
   logic [1:0]                 burst_owner;
   logic [5:0]                 wait_cnt;

   logic [NUM_REQ-1:0] eligible;
   logic               accept_any;
   logic [1:0]         winner;
   logic [SLOT_W-1:0]  winner_slot;
   logic [SLOT_W-1:0]  next_slot;
   logic               slot_start;
   logic               start_fire;
   logic               start_miss;
   logic               drop_timeout;

   assign slot_start   = slot_strobe && tbl_valid[slot_index];
   assign start_fire   = slot_start && (state == IDLE) && is_armed;
   assign start_miss   = slot_start && !start_fire;
   assign drop_timeout = (state == WAIT_DROP) && is_armed && (wait_cnt == DROP_LAST);

   // A slot whose start is being evaluated at the next edge cannot be reserved now.
   always_comb begin
      next_slot = slot_index + 1'b1;
      eligible  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i]
                       && !tbl_valid[req_slot[i*SLOT_W +: SLOT_W]]
                       && !((timer == TIMER_LAST) && (next_slot == req_slot[i*SLOT_W +: SLOT_W]));
      end
   end

   // Round-robin search starting at rr_ptr; first eligible requester wins.
   always_comb begin
      accept_any  = 1'b0;
      winner      = '0;
      winner_slot = '0;
      req_ready   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!accept_any && eligible[i] && (((32'(rr_ptr) + k) % NUM_REQ) == i)) begin
               accept_any = 1'b1;
               winner     = 2'(i);
            end
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner == 2'(i)) begin
            winner_slot = req_slot[i*SLOT_W +: SLOT_W];
         end
         req_ready[i] = accept_any && reset_n && (winner == 2'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      fire_burst  = 1'b0;
      grant_valid = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if (start_fire) state_next = FIRE;
         end
         FIRE: begin
            fire_burst  = 1'b1;
            grant_valid = 1'b1;
            busy        = 1'b1;
            state_next  = WAIT_DROP;
         end
         WAIT_DROP: begin
            busy = 1'b1;
            if (!is_armed) begin
               state_next = BUSY;
            end else if (drop_timeout) begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (is_armed) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         timer       <= '0;
         slot_index  <= '0;
         frame_count <= '0;
         slot_strobe <= 1'b0;
         tbl_valid   <= '0;
         for (int unsigned s = 0; s < SLOTS_PER_FRAME; s++) begin
            tbl_owner[s] <= '0;
         end
         rr_ptr      <= '0;
         burst_owner <= '0;
         wait_cnt    <= '0;
         miss_valid  <= 1'b0;
         owner_id    <= '0;
      end else begin
         slot_strobe <= (timer == TIMER_LAST);
         if (timer == TIMER_LAST) begin
            timer      <= '0;
            slot_index <= slot_index + 1'b1;
            if (slot_index == SLOT_LAST) begin
               frame_count <= frame_count + 16'd1;
            end
         end else begin
            timer <= timer + 1'b1;
         end

         wait_cnt <= (state == WAIT_DROP) ? wait_cnt + 1'b1 : '0;

         // Accept and slot-start clear never touch the same entry: one needs it invalid, the other valid.
         if (accept_any) begin
            tbl_valid[winner_slot] <= 1'b1;
            tbl_owner[winner_slot] <= winner;
            rr_ptr <= (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;
         end

         miss_valid <= 1'b0;
         if (drop_timeout) begin
            miss_valid <= 1'b1;
            owner_id   <= burst_owner;
         end
         if (slot_start) begin
            tbl_valid[slot_index] <= 1'b0;
            owner_id              <= tbl_owner[slot_index];
            if (start_miss) miss_valid <= 1'b1;
            if (start_fire) burst_owner <= tbl_owner[slot_index];
         end
      end
   end

endmodule

// File: tb/tb_tdma_burst_scheduler.sv
// Directed bench for tdma_burst_scheduler: timing table plus hand-written
// reservation, arbitration, miss and mid-frame reset sequences.
module tb_tdma_burst_scheduler;

   localparam int unsigned CPS = 16;
   localparam int unsigned SPF = 4;
   localparam int unsigned NR  = 2;
   localparam int unsigned SW  = 2;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic [NR-1:0]  req_valid = '0;
   logic [NR*SW-1:0] req_slot = '0;
   logic [NR-1:0]  req_ready;
   logic           is_armed = 1'b0;
   logic           fire_burst, grant_valid, miss_valid, slot_strobe, busy;
   logic [1:0]     owner_id;
   logic [SW-1:0]  slot_index;
   logic [15:0]    frame_count;

   int unsigned n_checks = 0, n_pass = 0;
   int unsigned clk_n = 0, fire_cnt = 0, miss_cnt = 0, strobe_cnt = 0;

   typedef struct {
      int unsigned cyc;
      logic        strobe;
      logic [1:0]  slot;
      logic [15:0] frame;
   } tvec_t;
   tvec_t tvec [9];

   always #5 clock = ~clock;

   tdma_burst_scheduler #(
      .CLOCKS_PER_SLOT(CPS),
      .SLOTS_PER_FRAME(SPF),
      .NUM_REQ(NR),
      .SLOT_W(SW)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_slot(req_slot),
      .req_ready(req_ready),
      .is_armed(is_armed),
      .fire_burst(fire_burst),
      .grant_valid(grant_valid),
      .miss_valid(miss_valid),
      .owner_id(owner_id),
      .slot_strobe(slot_strobe),
      .slot_index(slot_index),
      .frame_count(frame_count),
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (clk %0d)", name, act, exp, clk_n);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      clk_n++;
      if (fire_burst)  fire_cnt++;
      if (miss_valid)  miss_cnt++;
      if (slot_strobe) strobe_cnt++;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [1:0] s0, input logic [1:0] s1);
      req_valid = v;
      req_slot  = {s1, s0};
      #1;
   endtask

   task automatic clear_counts();
      clk_n = 0; fire_cnt = 0; miss_cnt = 0; strobe_cnt = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      set_req(2'b00, 2'd0, 2'd0);
      tick();
      tick();
      reset_n = 1'b1;
      clear_counts();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tvec[0] = '{15,  1'b0, 2'd0, 16'd0};
      tvec[1] = '{16,  1'b1, 2'd1, 16'd0};
      tvec[2] = '{17,  1'b0, 2'd1, 16'd0};
      tvec[3] = '{32,  1'b1, 2'd2, 16'd0};
      tvec[4] = '{48,  1'b1, 2'd3, 16'd0};
      tvec[5] = '{63,  1'b0, 2'd3, 16'd0};
      tvec[6] = '{64,  1'b1, 2'd0, 16'd1};
      tvec[7] = '{80,  1'b1, 2'd1, 16'd1};
      tvec[8] = '{200, 1'b0, 2'd0, 16'd3};

      // Reset state and free-running timing
      do_reset();
      check("reset outputs",
            {fire_burst, grant_valid, miss_valid, owner_id, slot_strobe, slot_index, frame_count, busy},
            '0);
      for (int v = 0; v < 9; v++) begin
         while (clk_n < tvec[v].cyc) tick();
         check($sformatf("t1 strobe@%0d", tvec[v].cyc), slot_strobe, tvec[v].strobe);
         check($sformatf("t1 slot@%0d", tvec[v].cyc), slot_index, tvec[v].slot);
         check($sformatf("t1 frame@%0d", tvec[v].cyc), frame_count, tvec[v].frame);
      end
      check("t1 strobe count", strobe_cnt, 12);
      check("t1 no fire/miss", fire_cnt + miss_cnt, 0);

      // Single reservation fired and transmitter handshake
      do_reset();
      is_armed = 1'b1;
      set_req(2'b01, 2'd2, 2'd0);
      check("t2 ready", req_ready, 2'b01);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      while (!fire_burst && clk_n < 60) tick();
      check("t2 fire clk", clk_n, 33);
      check("t2 grant", grant_valid, 1);
      check("t2 owner", owner_id, 0);
      check("t2 busy in fire", busy, 1);
      repeat (3) tick();
      check("t2 fire once", fire_cnt, 1);
      is_armed = 1'b0;
      repeat (20) tick();
      check("t2 busy before rearm", busy, 1);
      is_armed = 1'b1;
      tick();
      check("t2 busy after rearm", busy, 0);
      check("t2 no miss", miss_cnt, 0);

      // Tie, blocked waiter, round-robin pointer, next-slot exclusion
      do_reset();
      is_armed = 1'b0;
      set_req(2'b11, 2'd1, 2'd1);
      check("t3 tie first", req_ready, 2'b01);
      tick();
      set_req(2'b10, 2'd1, 2'd1);
      check("t3 req1 blocked", req_ready, 2'b00);
      while (!req_ready[1] && clk_n < 40) tick();
      check("t3 req1 accept clk", clk_n, 17);
      check("t3 miss slot1", miss_valid, 1);
      check("t3 miss owner", owner_id, 0);
      tick();
      set_req(2'b11, 2'd3, 2'd3);
      check("t3 tie ptr0", req_ready, 2'b01);
      tick();
      set_req(2'b11, 2'd0, 2'd0);
      check("t3 tie ptr1", req_ready, 2'b10);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      while (clk_n < 31) tick();
      set_req(2'b01, 2'd2, 2'd0);
      check("t3 next-slot excluded", req_ready, 2'b00);
      tick();
      check("t3 accept at strobe", req_ready, 2'b01);
      tick();
      set_req(2'b00, 2'd0, 2'd0);

      // Grant for slot 1, miss for slot 2 while transmitter still busy
      do_reset();
      is_armed = 1'b1;
      set_req(2'b01, 2'd1, 2'd0);
      check("t4 ready0", req_ready, 2'b01);
      tick();
      set_req(2'b10, 2'd0, 2'd2);
      check("t4 ready1", req_ready, 2'b10);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      while (!fire_burst && clk_n < 40) tick();
      check("t4 fire clk", clk_n, 17);
      check("t4 grant owner", {grant_valid, owner_id}, {1'b1, 2'd0});
      repeat (3) tick();
      is_armed = 1'b0;
      while (!miss_valid && clk_n < 60) tick();
      check("t4 miss clk", clk_n, 33);
      check("t4 miss owner", owner_id, 1);
      check("t4 no second fire", fire_cnt, 1);

      // Miss when not armed, entry freed for re-reservation
      do_reset();
      is_armed = 1'b0;
      set_req(2'b01, 2'd3, 2'd0);
      check("t5 ready", req_ready, 2'b01);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      while (clk_n < 48) tick();
      set_req(2'b10, 2'd0, 2'd3);
      check("t5 occupied at strobe", req_ready, 2'b00);
      tick();
      check("t5 miss", {miss_valid, owner_id}, {1'b1, 2'd0});
      check("t5 rereserve", req_ready, 2'b10);
      check("t5 no fire", fire_cnt, 0);
      tick();
      set_req(2'b00, 2'd0, 2'd0);

      // Reset during slot 1 drops the slot-2 reservation
      do_reset();
      is_armed = 1'b1;
      set_req(2'b01, 2'd2, 2'd0);
      check("t6 ready", req_ready, 2'b01);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      while (clk_n < 20) tick();
      reset_n = 1'b0;
      set_req(2'b01, 2'd2, 2'd0);
      tick();
      check("t6 ready gated in reset", req_ready, 2'b00);
      check("t6 state cleared", {slot_strobe, slot_index, frame_count, busy}, '0);
      reset_n = 1'b1;
      set_req(2'b00, 2'd0, 2'd0);
      clear_counts();
      while (clk_n < 16) tick();
      check("t6 first strobe", {slot_strobe, slot_index}, {1'b1, 2'd1});
      while (clk_n < 100) tick();
      check("t6 no fire/miss", fire_cnt + miss_cnt, 0);
      check("t6 slot/frame@100", {frame_count, slot_index}, {16'd1, 2'd2});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
